// File: rtl/count_event_fifo.sv
// count_event_fifo: captures {err,dir,count} on each end-count rising edge into a FIFO read over an 8-bit host bus.
// Optional macro CAPTURE_ERR_EN: a rising edge of err also pushes an entry.
module count_event_fifo #(
  parameter int CW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] count,
  input  logic          ec,
  input  logic          dir,
  input  logic          err,
  inout  wire  [7:0]    din,
  input  logic          ncs,
  input  logic          nrd,
  input  logic          nwr,
  input  logic          a0,
  input  logic          a1,
  output logic          irq,
  output logic          full
);

  typedef struct packed {
    logic          err;
    logic          dir;
    logic [CW-1:0] count;
  } entry_t;

  localparam logic [1:0]  ADDR_DATA   = 2'b00;
  localparam logic [1:0]  ADDR_STATUS = 2'b01;
  localparam logic [1:0]  ADDR_FLAGS  = 2'b10;
  localparam logic [1:0]  ADDR_CTRL   = 2'b11;
  localparam logic [AW:0] LEVEL_FULL  = (AW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        hold_q, hold_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          ec_q, nrd_q, nwr_q;
  logic [1:0]    addr;
  logic          push_req, pop_req, ctrl_wr, flush, clr_ovf;
  logic          fifo_empty, fifo_full, do_push, do_pop;
  logic [7:0]    rd_data;
  logic          bus_drive;
  logic          unused_din;

  assign addr       = {a1, a0};
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LEVEL_FULL);

`ifdef CAPTURE_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b1;
    else       err_q <= err;
  end
  // Simultaneous ec and err edges collapse into a single entry.
  assign push_req = (ec & ~ec_q) | (err & ~err_q);
`else
  assign push_req = ec & ~ec_q;
`endif

  // Strobes act on their falling edge; a read strobe masks a concurrent CTRL write.
  assign pop_req    = ~ncs & ~nrd & nrd_q & (addr == ADDR_DATA);
  assign ctrl_wr    = ~ncs & ~nwr & nwr_q & nrd & (addr == ADDR_CTRL);
  assign flush      = ctrl_wr & din[0];
  assign clr_ovf    = ctrl_wr & din[1];
  assign unused_din = ^din[7:2];

  assign do_pop  = pop_req & ~fifo_empty;
  assign do_push = push_req & ~flush & (~fifo_full | do_pop);

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    hold_d   = hold_q;
    if (pop_req) hold_d = do_pop ? mem_q[rd_ptr_q] : '0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
    if (clr_ovf) ovf_d = 1'b0;
    else if (push_req & ~flush & fifo_full & ~do_pop) ovf_d = 1'b1;
  end

  // NOTE: storage is left unreset; level and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_t'{err: err, dir: dir, count: count};
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      hold_q   <= '0;
      ec_q     <= 1'b1;
      nrd_q    <= 1'b1;
      nwr_q    <= 1'b1;
      irq      <= 1'b0;
      full     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
      ec_q     <= ec;
      nrd_q    <= nrd;
      nwr_q    <= nwr;
      irq      <= (level_d != '0);
      full     <= (level_d == LEVEL_FULL);
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_DATA:   rd_data = 8'(hold_q.count);
      ADDR_STATUS: rd_data = {ovf_q, fifo_full, fifo_empty, 1'b0, 4'(level_q)};
      ADDR_FLAGS:  rd_data = {6'b0, hold_q.err, hold_q.dir};
      default:     rd_data = 8'h00;
    endcase
  end

  // Bus is driven from the second strobe cycle on, giving DATA its one-cycle hold latency.
  assign bus_drive = ~ncs & ~nrd & ~nrd_q;
  assign din       = bus_drive ? rd_data : 8'bz;

endmodule

// File: tb/tb_count_event_fifo.sv
// Self-checking bench for count_event_fifo: directed scenarios plus random traffic against a queue model.
module tb_count_event_fifo;

  logic       clk = 1'b0;
  logic       reset, ec, dir, err, ncs, nrd, nwr, a0, a1;
  logic [7:0] count;
  wire  [7:0] din;
  logic       tb_drv;
  logic [7:0] tb_dout;
  logic       irq, full;
  int         checks = 0;
  int         errors = 0;

  typedef struct packed {
    logic       err;
    logic       dir;
    logic [7:0] count;
  } ent_t;

  ent_t q[$];
  logic m_ovf;
  ent_t m_hold;

  assign din = tb_drv ? tb_dout : 8'bz;
  always #5 clk = ~clk;

  count_event_fifo dut (
    .clk(clk), .reset(reset), .count(count), .ec(ec), .dir(dir), .err(err),
    .din(din), .ncs(ncs), .nrd(nrd), .nwr(nwr), .a0(a0), .a1(a1),
    .irq(irq), .full(full)
  );

  // ---------------- reference model ----------------
  function automatic void model_push(ent_t e);
    if (q.size() < 8) q.push_back(e);
    else m_ovf = 1'b1;
  endfunction

  function automatic void model_pop();
    if (q.size() == 0) m_hold = '0;
    else m_hold = q.pop_front();
  endfunction

  function automatic logic [7:0] exp_status();
    int n = q.size();
    return {m_ovf, n == 8, n == 0, 1'b0, 4'(n)};
  endfunction

  // ---------------- bus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_event(input logic [7:0] c, input logic d, input logic e, input int hold);
    count = c; dir = d; err = e; ec = 1'b1;
    model_push('{err: e, dir: d, count: c});
    for (int i = 0; i < hold; i++) begin
      tick();
      count = 8'($urandom);
      dir   = 1'($urandom);
    end
    ec = 1'b0; err = 1'b0;
    tick();
  endtask

  task automatic read_reg(input logic [1:0] addr, output logic [7:0] data);
    ncs = 1'b0; {a1, a0} = addr; nrd = 1'b0;
    if (addr == 2'b00) model_pop();
    tick();
    @(negedge clk);
    data = din;
    tick();
    nrd = 1'b1; ncs = 1'b1;
    tick();
  endtask

  task automatic ctrl_write(input logic [7:0] d);
    ncs = 1'b0; {a1, a0} = 2'b11; tb_dout = d; tb_drv = 1'b1; nwr = 1'b0;
    if (d[0]) q.delete();
    if (d[1]) m_ovf = 1'b0;
    tick();
    tick();
    nwr = 1'b1; ncs = 1'b1; tb_drv = 1'b0;
    tick();
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    if (irq !== (q.size() != 0) || full !== (q.size() == 8)) begin
      errors++;
      $display("FAIL %s irq/full: got %b/%b expected %b/%b", tag, irq, full, q.size() != 0, q.size() == 8);
    end
  endtask

  task automatic check_status(input string tag);
    logic [7:0] v;
    read_reg(2'b01, v);
    checks++;
    if (v !== exp_status()) begin
      errors++;
      $display("FAIL %s status: got %h expected %h", tag, v, exp_status());
    end
  endtask

  task automatic check_data(input string tag);
    logic [7:0] v;
    read_reg(2'b00, v);
    checks++;
    if (v !== m_hold.count) begin
      errors++;
      $display("FAIL %s data: got %0d expected %0d", tag, v, m_hold.count);
    end
  endtask

  task automatic check_flags(input string tag);
    logic [7:0] v;
    read_reg(2'b10, v);
    checks++;
    if (v !== {6'b0, m_hold.err, m_hold.dir}) begin
      errors++;
      $display("FAIL %s flags: got %h expected %h", tag, v, {6'b0, m_hold.err, m_hold.dir});
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    q.delete(); m_ovf = 1'b0; m_hold = '0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (irq !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset irq/full: got %b/%b expected 0/0", irq, full);
    end
    check_status("reset");
    checks++;
    if (exp_status() !== 8'h20) begin
      errors++;
      $display("FAIL reset model status: got %h expected 20", exp_status());
    end
  endtask

  task automatic test_single_entry();
    push_event(8'd5, 1'b0, 1'b0, 3);
    check_outputs("single push");
    check_status("single level");
    check_data("single data");
    check_flags("single flags");
    check_outputs("single drained");
    // With ncs high the DUT must leave the bus alone even while nrd is low.
    ncs = 1'b1; nrd = 1'b0; {a1, a0} = 2'b00; tb_dout = 8'h00; tb_drv = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (din !== 8'h00) begin
      errors++;
      $display("FAIL bus release: got %h expected 00", din);
    end
    tick();
    nrd = 1'b1; tb_drv = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      push_event(8'(i), 1'b1, 1'b0, 1);
      if (i == 8) check_outputs("fill to full");
    end
    check_outputs("overflow");
    check_status("overflow status");
    for (int i = 1; i <= 8; i++) check_data("overflow drain");
    check_status("drained ovf sticky");
    ctrl_write(8'h02);
    check_status("ovf cleared");
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 8; i++) push_event(8'(10 + i), 1'b0, 1'b0, 1);
    ncs = 1'b0; {a1, a0} = 2'b00; nrd = 1'b0;
    count = 8'd99; dir = 1'b1; err = 1'b0; ec = 1'b1;
    model_pop();
    model_push('{err: 1'b0, dir: 1'b1, count: 8'd99});
    tick();
    @(negedge clk);
    checks++;
    if (din !== m_hold.count) begin
      errors++;
      $display("FAIL full pop+push data: got %0d expected %0d", din, m_hold.count);
    end
    tick();
    ec = 1'b0; nrd = 1'b1; ncs = 1'b1;
    tick();
    check_outputs("full pop+push");
    check_status("full pop+push status");
    for (int i = 0; i < 8; i++) check_data("full pop+push drain");
    checks++;
    if (m_hold.count !== 8'd99) begin
      errors++;
      $display("FAIL full pop+push last: got %0d expected 99", m_hold.count);
    end
  endtask

  task automatic test_empty_pop_push();
    ncs = 1'b0; {a1, a0} = 2'b00; nrd = 1'b0;
    count = 8'd42; dir = 1'b0; err = 1'b1; ec = 1'b1;
    model_pop();
    model_push('{err: 1'b1, dir: 1'b0, count: 8'd42});
    tick();
    @(negedge clk);
    checks++;
    if (din !== 8'h00) begin
      errors++;
      $display("FAIL empty pop+push data: got %h expected 00", din);
    end
    tick();
    ec = 1'b0; err = 1'b0; nrd = 1'b1; ncs = 1'b1;
    tick();
    check_status("empty pop+push status");
    check_data("empty pop+push entry");
    check_flags("empty pop+push flags");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_event(8'(30 + i), 1'b1, 1'b0, 2);
    ctrl_write(8'h03);
    check_outputs("flush");
    check_status("flush status");
    check_data("flush read empty");
    // Flush coinciding with a push: the push is dropped.
    push_event(8'd7, 1'b0, 1'b0, 1);
    ncs = 1'b0; {a1, a0} = 2'b11; tb_dout = 8'h01; tb_drv = 1'b1; nwr = 1'b0;
    count = 8'd8; ec = 1'b1;
    q.delete();
    tick();
    ec = 1'b0;
    tick();
    nwr = 1'b1; ncs = 1'b1; tb_drv = 1'b0;
    tick();
    check_outputs("flush+push");
    check_status("flush+push status");
  endtask

  task automatic test_err_edge();
    count = 8'd200; dir = 1'b1; ec = 1'b0; err = 1'b1;
`ifdef CAPTURE_ERR_EN
    model_push('{err: 1'b1, dir: 1'b1, count: 8'd200});
`endif
    tick();
    tick();
    err = 1'b0;
    tick();
    check_status("err edge status");
    check_data("err edge data");
    check_flags("err edge flags");
  endtask

  task automatic test_reset_mid_read();
    push_event(8'd77, 1'b1, 1'b0, 1);
    ncs = 1'b0; {a1, a0} = 2'b01; nrd = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete(); m_ovf = 1'b0; m_hold = '0;
    tb_dout = 8'h00; tb_drv = 1'b1;
    @(negedge clk);
    checks++;
    if (din !== 8'h00) begin
      errors++;
      $display("FAIL reset mid-read bus: got %h expected 00", din);
    end
    tick();
    tb_drv = 1'b0; nrd = 1'b1; ncs = 1'b1;
    tick();
    check_outputs("reset mid-read");
    check_status("reset mid-read status");
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: push_event(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 3));
        4, 5:       check_data("rand data");
        6:          check_status("rand status");
        7:          check_flags("rand flags");
        8:          ctrl_write({6'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0)});
        default:    tick();
      endcase
      check_outputs("rand");
    end
  endtask

  initial begin
    reset = 1'b1; ec = 1'b0; dir = 1'b0; err = 1'b0; count = '0;
    ncs = 1'b1; nrd = 1'b1; nwr = 1'b1; a0 = 1'b0; a1 = 1'b0;
    tb_drv = 1'b0; tb_dout = '0;
    m_ovf = 1'b0; m_hold = '0;
    test_reset();
    test_single_entry();
    test_overflow();
    test_full_pop_push();
    test_empty_pop_push();
    test_flush();
    test_err_edge();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
